// File: rtl/repl_ctrl_if.sv
// ============================================================================
// Module : repl_ctrl_if
// Brief  : Lookup-result, victim-offer, fill and LRU-array signals of repl_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface repl_ctrl_if #(
    parameter int ASSOC      = 8,
    parameter int INDEX_SIZE = 7
);
    localparam int WAY_W = $clog2(ASSOC);

    logic                  req_valid;
    logic                  req_ready;
    logic [INDEX_SIZE-1:0] req_index;
    logic                  req_hit;
    logic [WAY_W-1:0]      req_way;
    logic                  victim_valid;
    logic                  victim_ready;
    logic [INDEX_SIZE-1:0] victim_index;
    logic [WAY_W-1:0]      victim_way;
    logic                  fill_done;
    logic [1:0]            lru_replace;
    logic [INDEX_SIZE-1:0] lru_index;
    logic [WAY_W-1:0]      lru_assoc;
    logic [WAY_W-1:0]      lru_victim;

    // Environment side: lookup pipeline, fill logic and LRU array.
    modport master (
        output req_valid, req_index, req_hit, req_way,
        output victim_ready, fill_done, lru_victim,
        input  req_ready, victim_valid, victim_index, victim_way,
        input  lru_replace, lru_index, lru_assoc
    );

    // Replacement controller side.
    modport slave (
        input  req_valid, req_index, req_hit, req_way,
        input  victim_ready, fill_done, lru_victim,
        output req_ready, victim_valid, victim_index, victim_way,
        output lru_replace, lru_index, lru_assoc
    );
endinterface

`default_nettype wire

// File: rtl/repl_ctrl.sv
// ============================================================================
// Module : repl_ctrl
// Brief  : Cache replacement controller sequencing LRU touch, victim offer and
//          fill. Optional hit/miss statistics under REPL_CTRL_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module repl_ctrl #(
    parameter int ASSOC      = 8,
    parameter int INDEX_SIZE = 7,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    repl_ctrl_if.slave bus
`ifdef REPL_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
`endif
);
    localparam int WAY_W = $clog2(ASSOC);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_TOUCH  = 3'd2,
        ST_SELECT = 3'd3,
        ST_OFFER  = 3'd4,
        ST_FILL   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [INDEX_SIZE-1:0] r_index;
    logic [WAY_W-1:0]      r_way;
    logic [WAY_W-1:0]      r_victim_way;
    logic                  w_accept;
    logic [1:0]            w_lru_replace;

    generate
        if (ASSOC < 2 || (ASSOC & (ASSOC - 1)) != 0 || CNT_W < 1 || INDEX_SIZE < 1) begin : g_cfg_bad
            $error("repl_ctrl: ASSOC must be a power of 2 >= 2; CNT_W and INDEX_SIZE >= 1");
        end
    endgenerate

    assign w_accept = (r_state == ST_IDLE) && bus.req_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_lru_replace = 2'b11;
        unique case (r_state)
            ST_INIT: begin
                w_lru_replace = 2'b00;
                w_next        = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_next = bus.req_hit ? ST_TOUCH : ST_SELECT;
                end
            end
            ST_TOUCH: begin
                w_lru_replace = 2'b01;
                w_next        = ST_IDLE;
            end
            ST_SELECT: w_next = ST_OFFER;
            ST_OFFER: begin
                if (bus.victim_ready) begin
                    w_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (bus.fill_done) begin
                    w_next = ST_TOUCH;
                end
            end
            default: begin
                w_lru_replace = 2'b00;
                w_next        = ST_INIT;
            end
        endcase
    end

    // r_way doubles as the touch target: hit way, or the victim once a miss is selected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index      <= '0;
            r_way        <= '0;
            r_victim_way <= '0;
        end else begin
            if (w_accept) begin
                r_index <= bus.req_index;
                if (bus.req_hit) begin
                    r_way <= bus.req_way;
                end
            end
            if (r_state == ST_SELECT) begin
                r_victim_way <= bus.lru_victim;
                r_way        <= bus.lru_victim;
            end
        end
    end

    assign bus.req_ready    = (r_state == ST_IDLE);
    assign bus.victim_valid = (r_state == ST_OFFER);
    assign bus.victim_index = r_index;
    assign bus.victim_way   = r_victim_way;
    assign bus.lru_replace  = w_lru_replace;
    assign bus.lru_index    = r_index;
    assign bus.lru_assoc    = r_way;

`ifdef REPL_CTRL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (w_accept) begin
            if (bus.req_hit) begin
                if (hit_cnt != {CNT_W{1'b1}}) begin
                    hit_cnt <= hit_cnt + 1'b1;
                end
            end else begin
                if (miss_cnt != {CNT_W{1'b1}}) begin
                    miss_cnt <= miss_cnt + 1'b1;
                end
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_repl_ctrl.sv
// ============================================================================
// Module : tb_repl_ctrl
// Brief  : Directed self-checking bench for repl_ctrl (ASSOC=8, INDEX_SIZE=7).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_repl_ctrl;
    localparam int ASSOC      = 8;
    localparam int INDEX_SIZE = 7;
    localparam int CNT_W      = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    repl_ctrl_if #(.ASSOC(ASSOC), .INDEX_SIZE(INDEX_SIZE)) bus ();

`ifdef REPL_CTRL_STATS_EN
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    repl_ctrl #(.ASSOC(ASSOC), .INDEX_SIZE(INDEX_SIZE), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );
`else
    repl_ctrl #(.ASSOC(ASSOC), .INDEX_SIZE(INDEX_SIZE), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one lookup in IDLE and let it be accepted at the next edge.
    task automatic lookup(input logic [6:0] idx, input logic hit, input logic [2:0] way);
        bus.req_valid = 1'b1;
        bus.req_index = idx;
        bus.req_hit   = hit;
        bus.req_way   = way;
        tick();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        errors           = 0;
        checks           = 0;
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_index    = '0;
        bus.req_hit      = 1'b0;
        bus.req_way      = '0;
        bus.victim_ready = 1'b0;
        bus.fill_done    = 1'b0;
        bus.lru_victim   = '0;
        repeat (2) tick();

        check("rst_lru_replace", 32'(bus.lru_replace), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_victim_valid", 32'(bus.victim_valid), 32'd0);
        check("rst_victim_way", 32'(bus.victim_way), 32'd0);
        check("rst_lru_index", 32'(bus.lru_index), 32'd0);
        check("rst_lru_assoc", 32'(bus.lru_assoc), 32'd0);

        rst = 1'b0;
        #1;
        check("init_lru_replace", 32'(bus.lru_replace), 32'd0);
        tick();
        check("idle_req_ready", 32'(bus.req_ready), 32'd1);
        check("idle_lru_replace", 32'(bus.lru_replace), 32'd3);

        // Hit: index 5 way 3
        lookup(7'd5, 1'b1, 3'd3);
        check("hit_lru_replace", 32'(bus.lru_replace), 32'd1);
        check("hit_lru_index", 32'(bus.lru_index), 32'd5);
        check("hit_lru_assoc", 32'(bus.lru_assoc), 32'd3);
        check("hit_req_ready_n1", 32'(bus.req_ready), 32'd0);
        tick();
        check("hit_req_ready_n2", 32'(bus.req_ready), 32'd1);
        check("hit_idle_lru_replace", 32'(bus.lru_replace), 32'd3);

        // Miss: index 9, LRU array names way 7
        bus.lru_victim = 3'd7;
        lookup(7'd9, 1'b0, 3'd1);
        check("sel_lru_replace", 32'(bus.lru_replace), 32'd3);
        check("sel_lru_index", 32'(bus.lru_index), 32'd9);
        check("sel_victim_valid", 32'(bus.victim_valid), 32'd0);
        check("sel_req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        bus.lru_victim = 3'd2;
        for (int i = 0; i < 3; i++) begin
            check("offer_victim_valid", 32'(bus.victim_valid), 32'd1);
            check("offer_victim_index", 32'(bus.victim_index), 32'd9);
            check("offer_victim_way", 32'(bus.victim_way), 32'd7);
            check("offer_lru_index", 32'(bus.lru_index), 32'd9);
            bus.fill_done = (i == 1);
            tick();
        end
        // Handshake with a same-cycle fill_done, which must be lost.
        bus.victim_ready = 1'b1;
        bus.fill_done    = 1'b1;
        tick();
        bus.victim_ready = 1'b0;
        bus.fill_done    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("fill_victim_valid", 32'(bus.victim_valid), 32'd0);
            check("fill_lru_replace", 32'(bus.lru_replace), 32'd3);
            check("fill_req_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.fill_done = 1'b1;
        tick();
        bus.fill_done = 1'b0;
        check("fill_touch_lru_replace", 32'(bus.lru_replace), 32'd1);
        check("fill_touch_lru_assoc", 32'(bus.lru_assoc), 32'd7);
        check("fill_touch_lru_index", 32'(bus.lru_index), 32'd9);
        tick();
        check("after_fill_req_ready", 32'(bus.req_ready), 32'd1);
        check("after_fill_lru_replace", 32'(bus.lru_replace), 32'd3);

        // Reset while the victim is on offer
        bus.lru_victim = 3'd4;
        lookup(7'd12, 1'b0, 3'd0);
        tick();
        check("offer2_victim_valid", 32'(bus.victim_valid), 32'd1);
        check("offer2_victim_way", 32'(bus.victim_way), 32'd4);
        rst = 1'b1;
        #1;
        check("rst_offer_victim_valid", 32'(bus.victim_valid), 32'd0);
        check("rst_offer_lru_replace", 32'(bus.lru_replace), 32'd0);
        check("rst_offer_victim_way", 32'(bus.victim_way), 32'd0);
        check("rst_offer_lru_index", 32'(bus.lru_index), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_offer_idle", 32'(bus.req_ready), 32'd1);

        // Reset during FILL, then a late fill_done
        bus.lru_victim = 3'd5;
        lookup(7'd20, 1'b0, 3'd0);
        tick();
        bus.victim_ready = 1'b1;
        tick();
        bus.victim_ready = 1'b0;
        check("fill2_lru_replace", 32'(bus.lru_replace), 32'd3);
        check("fill2_victim_valid", 32'(bus.victim_valid), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_fill_lru_replace", 32'(bus.lru_replace), 32'd0);
        check("rst_fill_victim_valid", 32'(bus.victim_valid), 32'd0);
        check("rst_fill_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_fill_lru_assoc", 32'(bus.lru_assoc), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_fill_init", 32'(bus.lru_replace), 32'd0);
        bus.fill_done = 1'b1;
        tick();
        bus.fill_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("late_fill_req_ready", 32'(bus.req_ready), 32'd1);
            check("late_fill_lru_replace", 32'(bus.lru_replace), 32'd3);
            tick();
        end

`ifdef REPL_CTRL_STATS_EN
        check("stats_hit_reset", 32'(hit_cnt), 32'd0);
        for (int i = 0; i < 17; i++) begin
            lookup(7'(i), 1'b1, 3'(i % 8));
            tick();
        end
        check("stats_hit_sat", 32'(hit_cnt), 32'd15);
        check("stats_miss", 32'(miss_cnt), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
